// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: steps an external LFSR, stores its 3-bit outputs in a buffer and streams them back.
// Optional macro SEQ_SKIP_ZERO_EN: zero captures are discarded and the LFSR is stepped again.
module lfsr_seq_ctrl #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 seed_in,
    input  logic                       cmd_new,
    input  logic                       cmd_append,
    input  logic                       cmd_play,
    output logic                       lfsr_load,
    output logic                       lfsr_en,
    output logic [7:0]                 lfsr_seed,
    input  logic [2:0]                 lfsr_r,
    output logic [2:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     seq_len,
    output logic                       busy,
    output logic                       full,
    output logic                       err
);
    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;
`ifdef SEQ_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, STEP, CAPTURE, PLAY} state_t;

    state_t        state;
    logic [2:0]    mem [DEPTH];
    logic [IW-1:0] idx;
    logic          last_idx;
    logic          any_cmd;

    assign any_cmd   = cmd_new | cmd_append | cmd_play;
    assign lfsr_load = state == LOAD;
    assign lfsr_en   = state == STEP;
    assign busy      = state != IDLE;
    assign full      = seq_len == LW'(DEPTH);
    assign last_idx  = LW'(idx) + LW'(1) == seq_len;
    assign out_valid = state == PLAY;
    assign out_data  = out_valid ? mem[idx] : 3'd0;
    assign out_last  = out_valid & last_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr_seed <= '0;
            seq_len   <= '0;
            idx       <= '0;
            err       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            // anything arriving outside IDLE is rejected; IDLE overrides below
            err <= busy & any_cmd;
            case (state)
                IDLE: begin
                    if (cmd_new) begin
                        lfsr_seed <= seed_in;
                        state     <= LOAD;
                        err       <= cmd_append | cmd_play;
                    end else if (cmd_append) begin
                        err <= full | cmd_play;
                        if (!full) state <= STEP;
                    end else if (cmd_play) begin
                        err <= seq_len == '0;
                        if (seq_len != '0) begin
                            idx   <= '0;
                            state <= PLAY;
                        end
                    end
                end
                LOAD: begin
                    seq_len <= '0;
                    state   <= IDLE;
                end
                STEP: state <= CAPTURE;
                CAPTURE: begin
                    if (SKIP_ZERO && lfsr_r == 3'd0) state <= STEP;
                    else begin
                        mem[seq_len[IW-1:0]] <= lfsr_r;
                        seq_len              <= seq_len + LW'(1);
                        state                <= IDLE;
                    end
                end
                PLAY: begin
                    if (out_ready) begin
                        if (last_idx) state <= IDLE;
                        else idx <= idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb_lfsr_seq_ctrl: randomized bench for lfsr_seq_ctrl with a companion LFSR stub and a queue-based model.
// Build with SEQ_SKIP_ZERO_EN defined to exercise the zero-skip variant.
module tb_lfsr_seq_ctrl;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef SEQ_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [7:0]    seed_in = '0;
    logic          cmd_new = 1'b0, cmd_append = 1'b0, cmd_play = 1'b0;
    logic          lfsr_load, lfsr_en;
    logic [7:0]    lfsr_seed;
    logic [2:0]    lfsr_r;
    logic [2:0]    out_data;
    logic          out_valid, out_last, busy, full, err;
    logic          out_ready = 1'b0;
    logic [LW-1:0] seq_len;

    int checks = 0;
    int errors = 0;

    logic [7:0] env = 8'h01;
    logic [7:0] m_lfsr;
    logic [2:0] q[$];
    logic [2:0] got_d[$];
    logic       got_l[$];
    int         held_bad, play_cycles;

    lfsr_seq_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .cmd_new(cmd_new),
        .cmd_append(cmd_append), .cmd_play(cmd_play), .lfsr_load(lfsr_load),
        .lfsr_en(lfsr_en), .lfsr_seed(lfsr_seed), .lfsr_r(lfsr_r),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .seq_len(seq_len), .busy(busy), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    // companion LFSR: Galois x^8+x^4+x^3+x^2+1, zero seed replaced by 1
    function automatic logic [7:0] lstep(input logic [7:0] s);
        return s[7] ? ({s[6:0], 1'b0} ^ 8'h1D) : {s[6:0], 1'b0};
    endfunction
    function automatic logic [2:0] ltap(input logic [7:0] s);
        return {s[7], s[3], s[0]};
    endfunction

    always @(posedge clk) begin
        if (lfsr_load) env <= (lfsr_seed == 8'h00) ? 8'h01 : lfsr_seed;
        else if (lfsr_en) env <= lstep(env);
    end
    assign lfsr_r = ltap(env);

    task automatic model_new(input logic [7:0] s);
        m_lfsr = (s == 8'h00) ? 8'h01 : s;
        q.delete();
    endtask

    task automatic model_append(output int pulses);
        logic [2:0] v;
        pulses = 0;
        do begin
            m_lfsr = lstep(m_lfsr);
            v = ltap(m_lfsr);
            pulses++;
        end while (SKIP && v == 3'd0);
        q.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic n, input logic a, input logic p, input logic [7:0] s);
        cmd_new = n; cmd_append = a; cmd_play = p; seed_in = s;
        tick();
        cmd_new = 1'b0; cmd_append = 1'b0; cmd_play = 1'b0; seed_in = '0;
    endtask

    task automatic wait_idle(output int en_cnt, output int cyc);
        en_cnt = 0; cyc = 0;
        while (busy && cyc < 200) begin
            en_cnt += int'(lfsr_en);
            tick();
            cyc++;
        end
    endtask

    task automatic run_play(input bit rnd);
        logic [2:0] pd;
        logic pl;
        bit r;
        int c;
        got_d.delete(); got_l.delete(); held_bad = 0; c = 0;
        issue(1'b0, 1'b0, 1'b1, 8'h00);
        while (out_valid && c < 300) begin
            r = rnd ? 1'($urandom_range(0, 1)) : (c % 2 == 0);
            out_ready = r; pd = out_data; pl = out_last;
            if (r) begin got_d.push_back(out_data); got_l.push_back(out_last); end
            tick();
            c++;
            if (!r && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl)) held_bad++;
        end
        out_ready = 1'b0;
        play_cycles = c;
    endtask

    task automatic test_reset();
        logic [24:0] all;
        #2 rst_n = 1'b0;
        cmd_new = 1'b1; cmd_append = 1'b1; seed_in = 8'hA5;
        repeat (3) tick();
        all = {lfsr_load, lfsr_en, lfsr_seed, out_data, out_valid, out_last, seq_len, busy, full, err};
        checks++;
        if (all !== '0) begin errors++; $display("FAIL reset_outputs got %0h exp 0", all); end
        cmd_new = 1'b0; cmd_append = 1'b0; seed_in = '0;
        #3 rst_n = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, lfsr_load, lfsr_seed, seq_len} !== '0)
            begin errors++; $display("FAIL reset_release got busy=%0b load=%0b seed=%0h len=%0d exp 0", busy, lfsr_load, lfsr_seed, seq_len); end
    endtask

    task automatic test_new();
        int loads;
        issue(1'b1, 1'b0, 1'b0, 8'h01);
        checks++;
        if (lfsr_load !== 1'b1 || lfsr_en !== 1'b0) begin errors++; $display("FAIL new_load got load=%0b en=%0b exp 1 0", lfsr_load, lfsr_en); end
        checks++;
        if (lfsr_seed !== 8'h01) begin errors++; $display("FAIL new_seed got %0h exp 01", lfsr_seed); end
        loads = 1;
        repeat (4) begin tick(); loads += int'(lfsr_load); end
        checks++;
        if (loads != 1) begin errors++; $display("FAIL new_load_pulses got %0d exp 1", loads); end
        checks++;
        if (seq_len !== '0 || busy !== 1'b0) begin errors++; $display("FAIL new_idle got len=%0d busy=%0b exp 0 0", seq_len, busy); end
    endtask

    logic [2:0] exp_dir[$];

    task automatic test_append();
        int n_app, exp_p, en_cnt, cyc;
`ifdef SEQ_SKIP_ZERO_EN
        n_app = 1; exp_p = 3; exp_dir = {3'b010};
`else
        n_app = 3; exp_p = 1; exp_dir = {3'b000, 3'b000, 3'b010};
`endif
        for (int i = 0; i < n_app; i++) begin
            issue(1'b0, 1'b1, 1'b0, 8'h00);
            wait_idle(en_cnt, cyc);
            checks++;
            if (en_cnt != exp_p) begin errors++; $display("FAIL append_en_pulses got %0d exp %0d", en_cnt, exp_p); end
            checks++;
            if (cyc != 2 * exp_p) begin errors++; $display("FAIL append_cycles got %0d exp %0d", cyc, 2 * exp_p); end
            checks++;
            if (seq_len !== LW'(i + 1)) begin errors++; $display("FAIL append_len got %0d exp %0d", seq_len, i + 1); end
        end
    endtask

    task automatic test_play_toggle();
        int n;
        bit ok;
        n = exp_dir.size();
        run_play(1'b0);
        ok = got_d.size() == n;
        for (int k = 0; k < got_d.size() && ok; k++)
            ok = got_d[k] === exp_dir[k] && got_l[k] === (k == n - 1);
        checks++;
        if (!ok) begin errors++; $display("FAIL play_stream got %0d items first=%0h exp %0d items first=%0h", got_d.size(), (got_d.size() > 0) ? got_d[0] : 3'd7, n, exp_dir[0]); end
        checks++;
        if (held_bad != 0) begin errors++; $display("FAIL play_hold got %0d unstable stalls exp 0", held_bad); end
        checks++;
        if (play_cycles != 2 * n - 1) begin errors++; $display("FAIL play_cycles got %0d exp %0d", play_cycles, 2 * n - 1); end
        checks++;
        if ({out_valid, out_data, out_last, busy} !== '0) begin errors++; $display("FAIL play_idle got v=%0b d=%0h l=%0b busy=%0b exp 0", out_valid, out_data, out_last, busy); end
        run_play(1'b1);
        ok = got_d.size() == n;
        for (int k = 0; k < got_d.size() && ok; k++) ok = got_d[k] === exp_dir[k];
        checks++;
        if (!ok) begin errors++; $display("FAIL replay_stream got %0d items exp %0d", got_d.size(), n); end
    endtask

    task automatic test_reject();
        int en_cnt, cyc, n;
        n = int'(seq_len);
        issue(1'b0, 1'b1, 1'b0, 8'h00);
        issue(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL busy_reject got err=%0b busy=%0b exp 1 1", err, busy); end
        wait_idle(en_cnt, cyc);
        checks++;
        if (seq_len !== LW'(n + 1) || err !== 1'b0) begin errors++; $display("FAIL busy_append_done got len=%0d err=%0b exp %0d 0", seq_len, err, n + 1); end
        issue(1'b1, 1'b1, 1'b0, 8'h3C);
        checks++;
        if (err !== 1'b1 || lfsr_load !== 1'b1 || lfsr_seed !== 8'h3C) begin errors++; $display("FAIL dual_cmd got err=%0b load=%0b seed=%0h exp 1 1 3c", err, lfsr_load, lfsr_seed); end
        en_cnt = 0;
        repeat (3) begin tick(); en_cnt += int'(lfsr_en); end
        checks++;
        if (en_cnt != 0 || seq_len !== '0 || busy !== 1'b0) begin errors++; $display("FAIL dual_only_load got en=%0d len=%0d busy=%0b exp 0 0 0", en_cnt, seq_len, busy); end
        issue(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL empty_play got err=%0b busy=%0b v=%0b exp 1 0 0", err, busy, out_valid); end
    endtask

    task automatic test_full();
        int en_cnt, cyc, p;
        logic [7:0] s;
        bit ok;
        s = 8'($urandom_range(0, 255));
        issue(1'b1, 1'b0, 1'b0, s);
        tick();
        model_new(s);
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b0, 1'b1, 1'b0, 8'h00);
            wait_idle(en_cnt, cyc);
            model_append(p);
        end
        checks++;
        if (seq_len !== LW'(DEPTH) || full !== 1'b1) begin errors++; $display("FAIL full_level got len=%0d full=%0b exp %0d 1", seq_len, full, DEPTH); end
        issue(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || seq_len !== LW'(DEPTH)) begin errors++; $display("FAIL full_append_err got err=%0b busy=%0b len=%0d exp 1 0 %0d", err, busy, seq_len, DEPTH); end
        run_play(1'b1);
        ok = got_d.size() == q.size();
        for (int k = 0; k < got_d.size() && ok; k++) ok = got_d[k] === q[k] && got_l[k] === (k == q.size() - 1);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_stream got %0d items exp %0d", got_d.size(), q.size()); end
        issue(1'b1, 1'b0, 1'b0, 8'h11);
        tick();
        checks++;
        if (seq_len !== '0 || full !== 1'b0) begin errors++; $display("FAIL full_clear got len=%0d full=%0b exp 0 0", seq_len, full); end
    endtask

    task automatic test_random();
        int n, en_cnt, cyc, p;
        logic [7:0] s;
        bit ok;
        for (int it = 0; it < 6; it++) begin
            s = (it == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            issue(1'b1, 1'b0, 1'b0, s);
            checks++;
            if (lfsr_seed !== s) begin errors++; $display("FAIL rand_seed got %0h exp %0h", lfsr_seed, s); end
            tick();
            model_new(s);
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                issue(1'b0, 1'b1, 1'b0, 8'h00);
                wait_idle(en_cnt, cyc);
                model_append(p);
                checks++;
                if (en_cnt != p) begin errors++; $display("FAIL rand_en_pulses got %0d exp %0d", en_cnt, p); end
            end
            checks++;
            if (seq_len !== LW'(n)) begin errors++; $display("FAIL rand_len got %0d exp %0d", seq_len, n); end
            repeat (2) begin
                run_play(1'b1);
                ok = got_d.size() == q.size() && held_bad == 0;
                for (int k = 0; k < got_d.size() && ok; k++) ok = got_d[k] === q[k] && got_l[k] === (k == q.size() - 1);
                checks++;
                if (!ok) begin errors++; $display("FAIL rand_stream got %0d items hold_bad=%0d exp %0d items", got_d.size(), held_bad, q.size()); end
            end
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_play_setup got v=%0b exp 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_last, seq_len, busy} !== '0) begin errors++; $display("FAIL reset_mid_play got v=%0b d=%0h len=%0d busy=%0b exp 0", out_valid, out_data, seq_len, busy); end
        #2 rst_n = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 8'h5A);
        tick();
        issue(1'b0, 1'b1, 1'b0, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({lfsr_en, busy, lfsr_seed} !== '0) begin errors++; $display("FAIL reset_mid_step got en=%0b busy=%0b seed=%0h exp 0", lfsr_en, busy, lfsr_seed); end
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_new();
        test_append();
        test_play_toggle();
        test_reject();
        test_full();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
